// File: rtl/fetch_seq.sv
// fetch_seq: opcode fetch, T-step sequencer and BRK injection for the 6502 core
module fetch_seq #(
  parameter int MAX_T = 7
) (
  input  logic             PHI0,
  input  logic             RES,
  input  logic             RDY,
  input  logic [7:0]       n_PD,
  input  logic             n_IMPLIED,
  input  logic             n_TWOCYCLE,
  input  logic             ENDX,
  input  logic             IRQ,
  input  logic             IFLAG,
  input  logic             NMI,
  output logic             Z_IR,
  output logic [7:0]       IR,
  output logic [MAX_T-1:0] TSTEP,
  output logic             SYNC,
  output logic             PC_INC,
  output logic [1:0]       INT_SRC,
  output logic             OVF
);
  logic rst_pend, nmi_pend, take_nmi, take_irq, imp, two, nmi_q;
  logic t1, last, use_nmi, nmi_edge;
  // fetch-cycle decode, end-of-instruction detection and PC increment request
  always_comb begin
    t1 = TSTEP[0];
    Z_IR = t1 & (rst_pend | take_nmi | take_irq);
    SYNC = t1;
    PC_INC = t1 ? ~Z_IR : TSTEP[1] ? ~(imp | (|INT_SRC)) : 1'b0;
    last = (TSTEP[1] & two) | ENDX | TSTEP[MAX_T-1];
    use_nmi = t1 & RDY & ~rst_pend & take_nmi;
    nmi_edge = NMI & ~nmi_q;
  end
  // step sequencer; NMI edge history keeps running through stalls
  always_ff @(posedge PHI0) begin
    if (RES) begin
      TSTEP <= MAX_T'(1);
      IR <= 8'h00;
      INT_SRC <= 2'b00;
      OVF <= 1'b0;
      rst_pend <= 1'b1;
      nmi_pend <= 1'b0;
      take_nmi <= 1'b0;
      take_irq <= 1'b0;
      imp <= 1'b0;
      two <= 1'b0;
      nmi_q <= 1'b0;
    end else begin
      nmi_q <= NMI;
      nmi_pend <= (nmi_pend & ~use_nmi) | nmi_edge;
      if (RDY && t1) begin
        IR <= ~n_PD;
        imp <= ~n_IMPLIED;
        two <= ~n_TWOCYCLE;
        INT_SRC <= rst_pend ? 2'b11 : take_nmi ? 2'b10 : take_irq ? 2'b01 : 2'b00;
        rst_pend <= 1'b0;
        take_nmi <= take_nmi & rst_pend;
        take_irq <= take_irq & (rst_pend | take_nmi);
        TSTEP <= MAX_T'(2);
      end else if (RDY) begin
        if (TSTEP[MAX_T-1] && !ENDX) OVF <= 1'b1;
        if (last) begin
          TSTEP <= MAX_T'(1);
          take_nmi <= nmi_pend;
          take_irq <= IRQ & ~IFLAG;
        end else begin
          TSTEP <= TSTEP << 1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: randomized and directed check of fetch_seq against a step-number model
module tb_fetch_seq;
  localparam int MAX_T = 7;
  logic phi0, res, rdy, n_implied, n_twocycle, endx, irq, iflag, nmi;
  logic [7:0] n_pd, ir;
  logic z_ir, sync, pc_inc, ovf;
  logic [MAX_T-1:0] tstep;
  logic [1:0] int_src;
  int errors = 0, checks = 0;

  fetch_seq #(.MAX_T(MAX_T)) dut (
    .PHI0(phi0), .RES(res), .RDY(rdy), .n_PD(n_pd), .n_IMPLIED(n_implied),
    .n_TWOCYCLE(n_twocycle), .ENDX(endx), .IRQ(irq), .IFLAG(iflag), .NMI(nmi),
    .Z_IR(z_ir), .IR(ir), .TSTEP(tstep), .SYNC(sync), .PC_INC(pc_inc),
    .INT_SRC(int_src), .OVF(ovf)
  );

  initial phi0 = 1'b0;
  always #5 phi0 = ~phi0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // reference model: current step as an integer plus pending-request booleans
  int mt = 1;
  logic [7:0] m_ir;
  logic [1:0] m_src;
  bit m_ovf, rp, np, tn, ti, mi, mtw, nprev, live, ed, used_nmi, last;
  always @(posedge phi0) begin
    if (res) begin
      mt = 1; m_ir = 8'h00; m_src = 2'b00; m_ovf = 0;
      rp = 1; np = 0; tn = 0; ti = 0; mi = 0; mtw = 0; nprev = 0; live = 1;
    end else if (live) begin
      ed = nmi && !nprev;
      nprev = nmi;
      used_nmi = 0;
      if (rdy) begin
        if (mt == 1) begin
          m_ir = ~n_pd;
          mi = !n_implied;
          mtw = !n_twocycle;
          if (rp) begin m_src = 2'd3; rp = 0; end
          else if (tn) begin m_src = 2'd2; tn = 0; used_nmi = 1; end
          else if (ti) begin m_src = 2'd1; ti = 0; end
          else m_src = 2'd0;
          mt = 2;
        end else begin
          last = (mt == 2 && mtw) || endx || mt == MAX_T;
          if (mt == MAX_T && !endx) m_ovf = 1;
          if (last) begin
            tn = np;
            ti = irq && !iflag;
            mt = 1;
          end else mt++;
        end
      end
      np = (np && !used_nmi) || ed;
    end
  end

  logic e_z, e_pc;
  logic [MAX_T-1:0] e_tstep;
  always_comb begin
    e_z = (mt == 1) && (rp || tn || ti);
    e_pc = (mt == 1) ? !e_z : (mt == 2) ? !(mi || m_src != 2'd0) : 1'b0;
    e_tstep = MAX_T'(1) << (mt - 1);
  end

  always @(negedge phi0) begin
    if (live) begin
      chk("tstep", 32'(tstep), 32'(e_tstep));
      chk("ir", 32'(ir), 32'(m_ir));
      chk("int_src", 32'(int_src), 32'(m_src));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("z_ir", 32'(z_ir), 32'(e_z));
      chk("sync", 32'(sync), 32'(mt == 1));
      chk("pc_inc", 32'(pc_inc), 32'(e_pc));
    end
  end

  logic pc_log [1:8];

  // runs one instruction until the sequencer is back in T1
  task automatic instr(input logic [7:0] op, input bit impl, input bit tw, input int end_at,
                       input int irq_from, input bit ifl, input int nmi_step,
                       input logic [8:0] stall_mask, input int stalls, input int res_step,
                       output int cyc);
    bit inj, twx, advanced, rdone;
    int e, st, guard;
    int scnt [0:8];
    inj = (mt == 1) ? e_z : (m_src != 2'd0);
    twx = tw && !inj;
    e = inj ? 7 : (twx ? 2 : end_at);
    advanced = 0; rdone = 0; guard = 0; cyc = 0;
    foreach (scnt[i]) scnt[i] = 0;
    while (guard < 60) begin
      st = mt;
      if (st == 1 && advanced) break;
      if (st != 1) advanced = 1;
      pc_log[st] = pc_inc;
      if (st == 1) begin
        n_pd = inj ? 8'hFF : ~op;
        n_implied = !(impl && !inj);
        n_twocycle = !twx;
        endx = 1'($urandom);
      end else begin
        n_pd = 8'($urandom);
        n_implied = 1'($urandom);
        n_twocycle = 1'($urandom);
        endx = (st == e);
      end
      irq = (irq_from < 0) ? 1'($urandom) : (irq_from > 0 && st >= irq_from);
      iflag = ifl;
      nmi = (st == nmi_step);
      rdy = 1'b1;
      if (stall_mask[st] && scnt[st] < stalls) begin
        rdy = 1'b0;
        scnt[st]++;
      end
      res = (st == res_step) && !rdone;
      if (res) rdone = 1;
      @(posedge phi0);
      #1;
      guard++;
      cyc++;
    end
    res = 1'b0;
    if (guard >= 60) begin
      checks++;
      errors++;
      $display("FAIL instr_timeout: got %0d cycles expected under 60", guard);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  int c;
  initial begin
    res = 1; rdy = 1; n_pd = 8'hFF; n_implied = 1; n_twocycle = 1;
    endx = 0; irq = 0; iflag = 0; nmi = 0;
    repeat (2) @(posedge phi0);
    #1;
    res = 0;
    chk("rst_tstep", 32'(tstep), 32'h1);
    chk("rst_zir", 32'(z_ir), 32'h1);
    chk("rst_pcinc", 32'(pc_inc), 32'h0);
    chk("rst_src", 32'(int_src), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    @(posedge phi0);
    #1;
    chk("rst_ir", 32'(ir), 32'h00);
    chk("rst_src3", 32'(int_src), 32'h3);
    chk("rst_t2", 32'(tstep), 32'h2);
    instr(8'h00, 0, 0, 7, 0, 0, 0, 9'h0, 0, 0, c);
    instr(8'hEA, 1, 1, 2, 0, 0, 0, 9'h0, 0, 0, c);
    chk("nop_ir", 32'(ir), 32'hEA);
    chk("nop_src", 32'(int_src), 32'h0);
    chk("nop_pc1", 32'(pc_log[1]), 32'h1);
    chk("nop_pc2", 32'(pc_log[2]), 32'h0);
    chk("nop_cyc", 32'(c), 32'd2);
    instr(8'hA9, 0, 1, 2, 0, 0, 0, 9'h0, 0, 0, c);
    chk("lda_ir", 32'(ir), 32'hA9);
    chk("lda_pc1", 32'(pc_log[1]), 32'h1);
    chk("lda_pc2", 32'(pc_log[2]), 32'h1);
    instr(8'hAD, 0, 0, 4, 2, 0, 0, 9'h0, 0, 0, c);
    chk("irq_cyc", 32'(c), 32'd4);
    chk("irq_zir", 32'(z_ir), 32'h1);
    instr(8'hAD, 0, 0, 4, 0, 0, 0, 9'h0, 0, 0, c);
    chk("irq_ir", 32'(ir), 32'h00);
    chk("irq_src", 32'(int_src), 32'h1);
    chk("irq_pc1", 32'(pc_log[1]), 32'h0);
    chk("irq_brk_cyc", 32'(c), 32'd7);
    instr(8'hAD, 0, 0, 4, 2, 1, 0, 9'h0, 0, 0, c);
    chk("masked_zir", 32'(z_ir), 32'h0);
    instr(8'hAD, 0, 0, 4, 0, 0, 0, 9'h0, 0, 0, c);
    chk("masked_src", 32'(int_src), 32'h0);
    chk("masked_ir", 32'(ir), 32'hAD);
    instr(8'hA5, 0, 0, 3, 1, 0, 2, 9'h0, 0, 0, c);
    chk("nmi_zir", 32'(z_ir), 32'h1);
    instr(8'hA5, 0, 0, 3, 1, 0, 0, 9'h0, 0, 0, c);
    chk("nmi_src", 32'(int_src), 32'h2);
    instr(8'hA5, 0, 0, 3, 0, 0, 0, 9'h0, 0, 0, c);
    chk("nmi_then_irq_src", 32'(int_src), 32'h1);
    instr(8'hAD, 0, 0, 4, 0, 0, 0, 9'b000001010, 3, 0, c);
    chk("stall_cyc", 32'(c), 32'd10);
    chk("stall_ir", 32'(ir), 32'hAD);
    chk("pre_ovf", 32'(ovf), 32'h0);
    instr(8'h0E, 0, 0, 8, 0, 0, 0, 9'h0, 0, 0, c);
    chk("ovf_cyc", 32'(c), 32'd7);
    chk("ovf_set", 32'(ovf), 32'h1);
    chk("ovf_t1", 32'(tstep), 32'h1);
    for (int k = 0; k < 300; k++) begin
      instr(8'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(3, 8),
            ($urandom_range(0, 3) == 0) ? -1 : ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0,
            1'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0,
            ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h0, $urandom_range(1, 3),
            ($urandom_range(0, 24) == 0) ? int'($urandom_range(2, 5)) : 0, c);
    end
    instr(8'h0E, 0, 0, 8, 0, 0, 0, 9'h0, 0, 0, c);
    instr(8'hAD, 0, 0, 6, 0, 0, 0, 9'h0, 0, 4, c);
    chk("midrst_ovf", 32'(ovf), 32'h0);
    chk("midrst_zir", 32'(z_ir), 32'h1);
    chk("midrst_tstep", 32'(tstep), 32'h1);
    instr(8'hAD, 0, 0, 4, 0, 0, 0, 9'h0, 0, 0, c);
    chk("midrst_src", 32'(int_src), 32'h3);
    @(negedge phi0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
